stdpipe: RTL



---
 rtl/stdpipe.sv | 128 ++++++++++++
 1 files changed

// File: rtl/stdpipe.sv
// stdpipe: valid/ready register slice with synchronous flush.
// Define STDPIPE_SKID_EN for the two-entry skid build; undefined gives the single-entry build.
module stdpipe #(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_pre_valid,
    output logic             o_pre_ready,
    input  logic [WIDTH-1:0] i_pre_data,
    output logic             o_post_valid,
    input  logic             i_post_ready,
    output logic [WIDTH-1:0] o_post_data
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
`ifdef STDPIPE_SKID_EN
    localparam logic [1:0] ST_TWO   = 2'd2;
`endif

    // Handshake: a transfer happens on a rising edge where valid & ready are both 1;
    // a valid payload is held stable until it transfers (flush may drop it).
    logic             up_fire;
    logic             dn_fire;
    logic [1:0]       state_dbg;

    logic             main_v_q, main_v_d;
    logic [WIDTH-1:0] main_d_q, main_d_d;
`ifdef STDPIPE_SKID_EN
    logic             skid_v_q, skid_v_d;
    logic [WIDTH-1:0] skid_d_q, skid_d_d;

    // Registered ready: a downstream stall reaches upstream one cycle late, the skid absorbs it.
    assign o_pre_ready = !skid_v_q;
`else
    assign o_pre_ready = !main_v_q | i_post_ready;
`endif

    assign o_post_valid = main_v_q;
    assign o_post_data  = main_d_q;
    assign up_fire      = i_pre_valid & o_pre_ready;
    assign dn_fire      = main_v_q & i_post_ready;

    always_comb begin
        state_dbg = ST_EMPTY;
        if (main_v_q) state_dbg = ST_ONE;
`ifdef STDPIPE_SKID_EN
        if (skid_v_q) state_dbg = ST_TWO;
`endif
    end

    always_comb begin
        main_v_d = main_v_q;
        main_d_d = main_d_q;
`ifdef STDPIPE_SKID_EN
        skid_v_d = skid_v_q;
        skid_d_d = skid_d_q;
`endif
        case (state_dbg)
            ST_EMPTY: begin
                if (up_fire) begin
                    main_v_d = 1'b1;
                    main_d_d = i_pre_data;
                end
            end
            ST_ONE: begin
                if (up_fire && dn_fire) begin
                    main_d_d = i_pre_data;
                end else if (dn_fire) begin
                    main_v_d = 1'b0;
                end
`ifdef STDPIPE_SKID_EN
                else if (up_fire) begin
                    skid_v_d = 1'b1;
                    skid_d_d = i_pre_data;
                end
`endif
            end
`ifdef STDPIPE_SKID_EN
            ST_TWO: begin
                if (dn_fire) begin
                    main_d_d = skid_d_q;
                    skid_v_d = 1'b0;
                end
            end
`endif
            default: begin
                main_v_d = 1'b0;
            end
        endcase

        // Squash drops every entry and discards this cycle's incoming payload; data regs keep old contents.
        if (i_flush) begin
            main_v_d = 1'b0;
            main_d_d = main_d_q;
`ifdef STDPIPE_SKID_EN
            skid_v_d = 1'b0;
            skid_d_d = skid_d_q;
`endif
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            main_v_q <= 1'b0;
            main_d_q <= RESET_VAL;
        end else begin
            main_v_q <= main_v_d;
            main_d_q <= main_d_d;
        end
    end

`ifdef STDPIPE_SKID_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            skid_v_q <= 1'b0;
            skid_d_q <= RESET_VAL;
        end else begin
            skid_v_q <= skid_v_d;
            skid_d_q <= skid_d_d;
        end
    end
`endif

endmodule
